// File: rtl/llr_load_ctrl_if.sv
// Bundle between the LLR frame loader, the sample source, the quantiser, the LLR
// memory and the decoder. master = loader side, slave = environment side.
interface llr_load_ctrl_if #(
   parameter int DATA_W = 6,
   parameter int ADDR_W = 10
);
   logic                     start;
   logic        [3:0]        cfg_snr_idx;
   logic signed [4:0]        cfg_frac_w;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [15:0]       in_data;
   logic        [3:0]        q_snr_idx;
   logic signed [4:0]        q_frac_w;
   logic signed [15:0]       q_data;
   logic signed [DATA_W-1:0] q_llr;
   logic                     mem_we;
   logic        [ADDR_W-1:0] mem_addr;
   logic signed [DATA_W-1:0] mem_wdata;
   logic                     frame_valid;
   logic                     dec_take;
   logic                     busy;
   logic        [ADDR_W:0]   sat_count;

   modport master (
      input  start, cfg_snr_idx, cfg_frac_w, in_valid, in_data, q_llr, dec_take,
      output in_ready, q_snr_idx, q_frac_w, q_data, mem_we, mem_addr, mem_wdata,
             frame_valid, busy, sat_count
   );

   modport slave (
      output start, cfg_snr_idx, cfg_frac_w, in_valid, in_data, q_llr, dec_take,
      input  in_ready, q_snr_idx, q_frac_w, q_data, mem_we, mem_addr, mem_wdata,
             frame_valid, busy, sat_count
   );
endinterface

// File: rtl/llr_load_ctrl.sv
// Loads one codeword of quantised channel LLRs into decoder memory, then offers it
// with a valid/take handshake. `define LLR_SAT_CNT_EN adds a saturated-LLR counter.
module llr_load_ctrl #(
   parameter int DATA_W = 6,
   parameter int N      = 648,
   parameter int ADDR_W = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   llr_load_ctrl_if.master      bus
);

   typedef enum logic [1:0] {IDLE, LOAD, LAST, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

   state_t                   state_q;
   logic        [ADDR_W-1:0] cnt_q, cnt_d;
   logic        [ADDR_W-1:0] addr_q;
   logic                     we_q;
   logic signed [15:0]       data_q;
   logic        [3:0]        snr_q;
   logic signed [4:0]        frac_q;
   logic                     hs;

   assign hs    = bus.in_valid && (state_q == LOAD);
   assign cnt_d = cnt_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         data_q  <= '0;
         snr_q   <= '0;
         frac_q  <= '0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  snr_q   <= bus.cfg_snr_idx;
                  frac_q  <= bus.cfg_frac_w;
                  cnt_q   <= '0;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               // Register the sample; the quantiser output is written next cycle.
               if (hs) begin
                  data_q <= bus.in_data;
                  we_q   <= 1'b1;
                  addr_q <= cnt_q;
                  cnt_q  <= cnt_d;
                  if (cnt_q == LAST_IDX) state_q <= LAST;
               end
            end
            LAST:    state_q <= DONE;
            DONE:    if (bus.dec_take) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = (state_q == LOAD);
   assign bus.busy        = (state_q != IDLE);
   assign bus.frame_valid = (state_q == DONE);
   assign bus.q_snr_idx   = snr_q;
   assign bus.q_frac_w    = frac_q;
   assign bus.q_data      = data_q;
   assign bus.mem_we      = we_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = bus.q_llr;

`ifdef LLR_SAT_CNT_EN
   logic [ADDR_W:0] sat_q;

   function automatic logic is_sat(input logic signed [DATA_W-1:0] v);
      return (v == {1'b0, {(DATA_W-1){1'b1}}}) || (v == {1'b1, {(DATA_W-1){1'b0}}});
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_q <= '0;
      end else if (state_q == IDLE && bus.start) begin
         sat_q <= '0;
      end else if (we_q && is_sat(bus.q_llr)) begin
         sat_q <= sat_q + 1'b1;
      end
   end

   assign bus.sat_count = sat_q;
`else
   assign bus.sat_count = '0;
`endif

endmodule

// File: tb/tb_llr_load_ctrl.sv
// Scoreboard bench for llr_load_ctrl with a behavioural quantiser stub.
module tb_llr_load_ctrl;

  localparam int DATA_W = 6;
  localparam int N      = 648;
  localparam int ADDR_W = 10;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_sat = 0;
  logic        [3:0] cur_snr  = '0;
  logic signed [4:0] cur_frac = '0;
  wr_t  sb[$];

  always #5 clk = ~clk;

  llr_load_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  llr_load_ctrl #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Quantiser stub: offset 10, gain (9+snr)/2^(13-frac), saturate to DATA_W.
  function automatic logic signed [DATA_W-1:0] quant(input logic signed [15:0] d,
                                                     input logic [3:0] s,
                                                     input logic signed [4:0] f);
    int v;
    v = 10 + ((int'(d) * (9 + int'(s))) >>> (13 - int'(f)));
    if (v > 31)  v = 31;
    if (v < -32) v = -32;
    return v[DATA_W-1:0];
  endfunction

  assign bus.q_llr = quant(bus.q_data, bus.q_snr_idx, bus.q_frac_w);

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] sample(input int mode);
    case (mode)
      0:       return 16'sh0000;
      1:       return 16'sh0800;
      2:       return 16'sh7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      if (sb.size() == 0) begin
        chk("extra_wr", 1, 0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", int'(bus.mem_addr), e.addr);
        chk("wr_data", int'(bus.mem_wdata), e.data);
      end
    end
  end

  task automatic rst_vals();
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_we",    int'(bus.mem_we), 0);
    chk("rst_fv",    int'(bus.frame_valid), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_qdata", int'(bus.q_data), 0);
    chk("rst_addr",  int'(bus.mem_addr), 0);
    chk("rst_snr",   int'(bus.q_snr_idx), 0);
    chk("rst_frac",  int'(bus.q_frac_w), 0);
    chk("rst_sat",   int'(bus.sat_count), 0);
  endtask

  task automatic do_start(input logic [3:0] snr, input logic signed [4:0] frac);
    bus.cfg_snr_idx = snr;
    bus.cfg_frac_w  = frac;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cur_snr   = snr;
    cur_frac  = frac;
    exp_sat   = 0;
    chk("start_busy",  int'(bus.busy), 1);
    chk("start_ready", int'(bus.in_ready), 1);
  endtask

  task automatic load_frame(input int mode, input bit gaps, input bit noise, input int abort_at);
    int acc = 0;
    int ld  = 0;
    int w   = 0;
    logic signed [15:0] s;
    logic signed [DATA_W-1:0] q;
    while (acc < N && ld < 20 * N) begin
      if (acc == abort_at) begin
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        rst_vals();
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_sat = 0;
        return;
      end
      chk("ld_ready", int'(bus.in_ready), 1);
      bus.in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      s = sample(mode);
      bus.in_data = s;
      bus.start = noise && ($urandom_range(0, 5) == 0);
      if (noise) begin
        bus.cfg_snr_idx = 4'($urandom_range(0, 15));
        bus.cfg_frac_w  = 5'($urandom_range(0, 10));
      end
      if (bus.in_valid) begin
        q = quant(s, cur_snr, cur_frac);
        sb.push_back('{acc, int'(q)});
        if (q == 6'sd31 || q == -6'sd32) exp_sat++;
        acc++;
      end
      @(posedge clk); #1;
      ld++;
    end
    bus.start = 1'b0;
    chk("ld_timeout", int'(ld < 20 * N), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sh7FFF;
    chk("last_ready", int'(bus.in_ready), 0);
    chk("last_fv",    int'(bus.frame_valid), 0);
    while (!bus.frame_valid && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    bus.in_valid = 1'b0;
    if (!gaps) chk("fv_latency", ld + 1 + w, N + 2);
    else       chk("fv_after_last", w, 1);
    chk("sb_empty",  sb.size(), 0);
    chk("done_busy", int'(bus.busy), 1);
    chk("cfg_snr",   int'(bus.q_snr_idx), int'(cur_snr));
    chk("cfg_frac",  int'(bus.q_frac_w), int'(cur_frac));
`ifdef LLR_SAT_CNT_EN
    chk("sat_count", int'(bus.sat_count), exp_sat);
`else
    chk("sat_count", int'(bus.sat_count), 0);
`endif
  endtask

  task automatic take();
    bus.dec_take = 1'b1;
    @(posedge clk); #1;
    bus.dec_take = 1'b0;
    chk("take_fv",   int'(bus.frame_valid), 0);
    chk("take_busy", int'(bus.busy), 0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.cfg_snr_idx = '0;
    bus.cfg_frac_w  = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.dec_take    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_vals();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy",  int'(bus.busy), 0);
    chk("idle_ready", int'(bus.in_ready), 0);

    do_start(4'd0, 5'sd2); load_frame(0, 1'b0, 1'b0, -1); take();
    do_start(4'd0, 5'sd2); load_frame(1, 1'b0, 1'b0, -1); take();
    do_start(4'd0, 5'sd2); load_frame(2, 1'b0, 1'b0, -1); take();
    do_start(4'd5, 5'sd4); load_frame(3, 1'b1, 1'b1, -1); take();

    do_start(4'd0, 5'sd2); load_frame(3, 1'b0, 1'b0, 300);
    chk("post_rst_busy", int'(bus.busy), 0);
    do_start(4'd0, 5'sd2); load_frame(0, 1'b0, 1'b0, -1);

    // Simultaneous start and take in DONE: take wins, start retried next cycle.
    bus.cfg_snr_idx = 4'd7;
    bus.cfg_frac_w  = 5'sd1;
    bus.start       = 1'b1;
    bus.dec_take    = 1'b1;
    @(posedge clk); #1;
    bus.dec_take = 1'b0;
    chk("tk_st_busy", int'(bus.busy), 0);
    chk("tk_st_fv",   int'(bus.frame_valid), 0);
    do_start(4'd3, 5'sd6);
    chk("restart_snr", int'(bus.q_snr_idx), 3);
    load_frame(1, 1'b0, 1'b0, -1);
    take();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/llr_load_ctrl.md
# llr_load_ctrl

Frame loader that sequences received channel samples through the `quant` LLR quantiser and writes one codeword of channel LLRs into the decoder's LLR input memory. It sits between the sample stream (valid/ready) and the LDPC decoder core. It latches the per-frame SNR and fraction-width configuration, drives the combinational quantiser from a register stage, and addresses the memory sequentially. It then hands the completed frame to the decoder with a valid/take handshake.

## Interface
- `DATA_W`, 6: LLR width; must match the quantiser's `data_w`.
- `N`, 648: codeword length in samples per frame.
- `ADDR_W`, 10: LLR memory address width; requires N ≤ 2^ADDR_W.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a frame; honoured only in IDLE.
- `cfg_snr_idx`  in  4  SNR LUT index; latched on accepted start.
- `cfg_frac_w`  in  5 signed  LLR fraction bits; latched on accepted start.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  sample ready.
- `in_data`  in  16 signed  received sample, Q5.11.
- `q_snr_idx`  out  4  to quantiser; latched config.
- `q_frac_w`  out  5 signed  to quantiser; latched config.
- `q_data`  out  16 signed  to quantiser; registered sample.
- `q_llr`  in  DATA_W signed  from quantiser (combinational).
- `mem_we`  out  1  LLR memory write enable.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data, equal to `q_llr`.
- `frame_valid`  out  1  complete frame resident in memory.
- `dec_take`  in  1  decoder accepts the frame.
- `busy`  out  1  high in any state other than IDLE.
- `sat_count`  out  ADDR_W+1  count of saturated LLRs in the frame (macro only).

## Operation
- State machine has four states: IDLE, LOAD, LAST, DONE.
- IDLE:
  - `in_ready`=0.
  - On `start`=1: latch `cfg_*` into `q_snr_idx`/`q_frac_w`, clear the sample counter and `sat_count`, then go to LOAD.
- LOAD:
  - `in_ready`=1, decoded from the state register.
  - Each handshake (`in_valid`&`in_ready`) registers `in_data` into `q_data`, sets the write-pending flag for the next cycle, and increments the counter.
  - The handshake that accepts sample N-1 moves the FSM to LAST.
- LAST: `in_ready`=0. Performs the final write, then goes to DONE.
- DONE:
  - `frame_valid`=1.
  - On `dec_take`=1, go to IDLE. `frame_valid` falls in the next cycle.
- Write stage: in the cycle after the handshake for sample k, `mem_we`=1, `mem_addr`=k, `mem_wdata`=`q_llr`. `mem_we`=0 in every other cycle.
- The address counter runs 0..N-1 and never wraps within a frame. It is cleared at the next accepted start.
- `start` is ignored in LOAD, LAST and DONE. `cfg_*` changes have no effect mid-frame.
- `start` and `dec_take` in the same DONE cycle: the take is honoured and the start is ignored. A new start is accepted in the following IDLE cycle.
- `rst` asserted mid-frame: all state returns to reset values immediately and the partial frame is discarded. Memory contents are undefined.
- Reset values:
  - state = IDLE.
  - `in_ready`, `mem_we`, `frame_valid`, `busy` = 0.
  - `q_data`, `mem_addr`, `q_snr_idx`, `q_frac_w`, `sat_count` = 0.

## Timing
- Sample-to-memory write latency: 1 cycle after the handshake.
- Throughput: 1 sample per cycle when `in_valid` is held high.
- Best-case frame time, from the cycle `start` is sampled to `frame_valid`=1: N+2 cycles.
  - Cycle 1: LOAD entered.
  - Cycles 1..N: samples accepted.
  - Cycle N+1: LAST, last write.
  - Cycle N+2: DONE.
- `in_valid` gaps stall the counter. `mem_we` deasserts in each cycle that follows a non-handshake cycle.
- `in_ready` falls in the cycle after the Nth handshake. Samples offered then are not consumed.

## Configuration
- `LLR_SAT_CNT_EN` defined:
  - Every write with `mem_wdata` = 2^(DATA_W-1)-1 or -2^(DATA_W-1) increments `sat_count`.
  - The count is valid while `frame_valid`=1 and is cleared on an accepted start.
- `LLR_SAT_CNT_EN` undefined: `sat_count` is tied to 0 and the counter logic is removed.

## Test plan
- Reset, then `start` with `cfg_snr_idx`=0, `cfg_frac_w`=2, and N samples of 0x0000 streamed back-to-back:
  - expect addresses 0..N-1, each `mem_wdata`=10;
  - `frame_valid` high exactly N+2 cycles after start;
  - `sat_count`=0.
- Same configuration, all samples 0x0800: every `mem_wdata`=19.
- Same configuration, all samples 0x7FFF: every `mem_wdata`=31; with `LLR_SAT_CNT_EN`, `sat_count`=N (else 0).
- Random `in_valid` gaps (≈50% duty) plus `start` pulses issued during LOAD:
  - no extra or missed writes;
  - addresses strictly sequential;
  - config unchanged by the ignored starts.
- `rst` asserted at sample 300:
  - all outputs return to reset values;
  - a new frame loads from address 0 with full N+2 timing.
- In DONE, assert `start` and `dec_take` together: FSM goes to IDLE with no load. A `start` in the next cycle is accepted, `busy`=1.
